decode_stage: RTL
=================

# decode_stage

Registered, parameterised RV32I/RV32E instruction decode stage for the Atom core, sitting between fetch and execute. Decodes the full RV32I base set (ALU, loads, stores, branches, jumps, LUI/AUIPC) into the execute control bundle. Provides valid/ready handshakes on both sides, with a one-entry skid buffer so that `ready_o` is a pure register output, plus a synchronous pipeline flush. Optionally flags illegal instructions and counts them.

## Interface
- `RF_ADDR_W`, default 5: register index width. 5 selects RV32I (32 registers); 4 selects RV32E (16 registers).
- `ILL_CNT_W`, default 16: width of the illegal-instruction counter.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset. One clock; reset is asynchronous and active-high.
- `flush_i`  in  1  synchronous kill of all held instructions.
- `valid_i`  in  1  fetch presents `instr_i`/`pc_i`.
- `ready_o`  out  1  stage can accept input.
- `instr_i`  in  32  instruction word.
- `pc_i`  in  32  instruction address.
- `valid_o`  out  1  decoded bundle valid.
- `ready_i`  in  1  execute accepts the bundle.
- `pc_o`  out  32  PC of the decoded instruction.
- `rd_sel_o`, `rs1_sel_o`, `rs2_sel_o`  out  RF_ADDR_W each  register indices, taken from the low bits of the instruction fields.
- `imm_o`  out  32  sign-extended immediate in I/S/B/U/J format.
- `rf_we_o`  out  1  register file write enable.
- `rf_din_sel_o`  out  2  write-back source: 0 imm, 1 pc+4, 2 alu, 3 load data.
- `a_op_sel_o`  out  1  ALU operand A: 0 rs1, 1 pc.
- `b_op_sel_o`  out  1  ALU operand B: 0 rs2, 1 imm.
- `alu_op_sel_o`  out  4  ADD 0, SUB 1, XOR 2, OR 3, AND 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9.
- `jump_en_o`  out  1  JAL/JALR.
- `branch_en_o`  out  1  conditional branch.
- `cmp_type_o`  out  3  branch condition: func3 passed through.
- `mem_re_o`, `mem_we_o`  out  1 each  load and store.
- `mem_width_o`  out  3  func3 of the load or store.
- `illegal_o`  out  1  instruction is illegal.
- `ill_count_o`  out  ILL_CNT_W  saturating count of illegal instructions delivered.

## Operation
- Decode is combinational on the incoming instruction. Results are captured into the output register (OUT) or into the skid register (SKID).
- **States:**
  - EMPTY: OUT invalid, SKID empty.
  - ONE: OUT valid, SKID empty.
  - TWO: OUT valid, SKID full.
- **Signal definitions:** accept = `valid_i & ready_o`; deliver = `valid_o & ready_i`.
- **Transitions:**
  - EMPTY, accept: go to ONE.
  - ONE, accept without deliver: incoming instruction goes to SKID; go to TWO.
  - ONE, accept with deliver: OUT reloads from input; stay in ONE.
  - ONE, deliver only: go to EMPTY.
  - TWO, deliver: OUT loads from SKID; go to ONE.
- `ready_o` is a register equal to (state != TWO). An accept in TWO cannot occur.
- `flush_i` has priority over all other events. Next state is EMPTY and `ready_o` is 1. An input accepted in the same cycle as a flush is discarded.
- **Decode rules:**
  - SUB and SRA are selected by `instr[30]`. SRLI/SRAI likewise.
  - JALR: `a_op_sel_o`=0, `b_op_sel_o`=1, ALU ADD, `rf_din_sel_o`=1.
  - Branches: `a_op_sel_o`=1, `b_op_sel_o`=1, ALU ADD computes the target.
  - FENCE decodes as a NOP.
  - `rf_we_o` is forced to 0 when rd = 0.
- `ill_count_o` increments on deliver when `illegal_o`=1 and saturates at all-ones.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Throughput is 1 instruction per cycle while `ready_i`=1.
- Outputs change only at clock edges. No combinational path exists from `ready_i` to `ready_o`.
- Order is strictly preserved: no instruction is lost or duplicated under any back-pressure pattern.
- **Reset values:** `ready_o` 1; `valid_o` 0; every bundle output 0, including `pc_o`, `imm_o`, `illegal_o` and `ill_count_o`. Reset asserted mid-operation drops all held instructions immediately.

## Configuration
- `DECODE_ILLEGAL_CHECK_EN` defined:
  - `illegal_o` is set for unknown opcodes and for reserved func3/func7 values.
  - It is also set when RF_ADDR_W=4 and any rd/rs1/rs2 field used by the instruction is ≥16.
  - When `illegal_o`=1, `rf_we_o`, `mem_we_o`, `mem_re_o`, `jump_en_o` and `branch_en_o` are forced to 0.
  - The counter is active.
- `DECODE_ILLEGAL_CHECK_EN` undefined:
  - `illegal_o` and `ill_count_o` are tied to 0.
  - Unknown encodings decode as a NOP with all enables 0.

## Test plan
- ADDI x1,x0,5 (0x00500093) with `ready_i`=1 → one cycle later: `valid_o`=1, `rd_sel_o`=1, `imm_o`=5, ALU 0, `b_op_sel_o`=1, `rf_din_sel_o`=2, `rf_we_o`=1.
- LUI x2 (0x12345137), then BEQ x1,x2,-8 (0xFE208CE3) at PC 0x100:
  - LUI → `imm_o`=0x12345000, `rf_din_sel_o`=0.
  - BEQ → `imm_o`=0xFFFFFFF8, `branch_en_o`=1, `cmp_type_o`=0, `rf_we_o`=0, `pc_o`=0x100.
- Back-pressure: hold `ready_i`=0 and offer 3 instructions → first two accepted, `ready_o`=0 after the second. Release `ready_i` → outputs in order A, B, then C is accepted.
- Flush while in state TWO, with `valid_i`=1 in the same cycle → next cycle `valid_o`=0, `ready_o`=1, and no instruction is later delivered.
- With `DECODE_ILLEGAL_CHECK_EN`:
  - 0x00000000 → `illegal_o`=1, `rf_we_o`=0, and `ill_count_o` reads 1 after delivery.
  - RF_ADDR_W=4 with ADD x17,x1,x2 (0x002088B3) → `illegal_o`=1.
- Reset asserted during a stalled TWO state → outputs go to their reset values asynchronously; after release, the first instruction accepted is decoded correctly.

Source files
------------

// File: rtl/decode_stage.sv
// Atom core RV32I/RV32E decode stage: valid/ready on both sides, one-entry skid buffer, synchronous flush.
// Define DECODE_ILLEGAL_CHECK_EN to flag illegal instructions and count them on delivery.
module decode_stage #(
    parameter int RF_ADDR_W = 5,
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [31:0]          instr_i,
    input  logic [31:0]          pc_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [31:0]          pc_o,
    output logic [RF_ADDR_W-1:0] rd_sel_o,
    output logic [RF_ADDR_W-1:0] rs1_sel_o,
    output logic [RF_ADDR_W-1:0] rs2_sel_o,
    output logic [31:0]          imm_o,
    output logic                 rf_we_o,
    output logic [1:0]           rf_din_sel_o,
    output logic                 a_op_sel_o,
    output logic                 b_op_sel_o,
    output logic [3:0]           alu_op_sel_o,
    output logic                 jump_en_o,
    output logic                 branch_en_o,
    output logic [2:0]           cmp_type_o,
    output logic                 mem_re_o,
    output logic                 mem_we_o,
    output logic [2:0]           mem_width_o,
    output logic                 illegal_o,
    output logic [ILL_CNT_W-1:0] ill_count_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]          pc;
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_ADDR_W-1:0] rs1;
        logic [RF_ADDR_W-1:0] rs2;
        logic [31:0]          imm;
        logic                 rf_we;
        logic [1:0]           din_sel;
        logic                 a_sel;
        logic                 b_sel;
        logic [3:0]           alu_op;
        logic                 jump;
        logic                 branch;
        logic [2:0]           cmp;
        logic                 mem_re;
        logic                 mem_we;
        logic [2:0]           mem_width;
        logic                 illegal;
    } bundle_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [1:0] DIN_IMM = 2'd0;
    localparam logic [1:0] DIN_PC4 = 2'd1;
    localparam logic [1:0] DIN_ALU = 2'd2;
    localparam logic [1:0] DIN_MEM = 2'd3;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    state_t      state_q;
    logic        valid_q;
    logic        ready_q;
    bundle_t     out_q;
    bundle_t     skid_q;
    bundle_t     dec_d;
    logic        accept;
    logic        deliver;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        known;
    logic        bad_fn;
    logic        illegal;

    assign accept  = valid_i & ready_q;
    assign deliver = valid_q & ready_i;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        dec_d     = '0;
        dec_d.pc  = pc_i;
        dec_d.rd  = instr_i[7 +: RF_ADDR_W];
        dec_d.rs1 = instr_i[15 +: RF_ADDR_W];
        dec_d.rs2 = instr_i[20 +: RF_ADDR_W];
        known     = 1'b1;
        bad_fn    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_d.imm     = imm_u;
                dec_d.rf_we   = 1'b1;
                dec_d.din_sel = DIN_IMM;
            end
            OPC_AUIPC: begin
                dec_d.imm     = imm_u;
                dec_d.rf_we   = 1'b1;
                dec_d.din_sel = DIN_ALU;
                dec_d.a_sel   = 1'b1;
                dec_d.b_sel   = 1'b1;
            end
            OPC_JAL: begin
                dec_d.imm     = imm_j;
                dec_d.rf_we   = 1'b1;
                dec_d.din_sel = DIN_PC4;
                dec_d.a_sel   = 1'b1;
                dec_d.b_sel   = 1'b1;
                dec_d.jump    = 1'b1;
            end
            OPC_JALR: begin
                dec_d.imm     = imm_i;
                dec_d.rf_we   = 1'b1;
                dec_d.din_sel = DIN_PC4;
                dec_d.b_sel   = 1'b1;
                dec_d.jump    = 1'b1;
                bad_fn        = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                // The ALU forms the target pc+imm; the comparator uses rs1/rs2 directly.
                dec_d.imm     = imm_b;
                dec_d.a_sel   = 1'b1;
                dec_d.b_sel   = 1'b1;
                dec_d.branch  = 1'b1;
                dec_d.cmp     = funct3;
                bad_fn        = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                dec_d.imm       = imm_i;
                dec_d.rf_we     = 1'b1;
                dec_d.din_sel   = DIN_MEM;
                dec_d.b_sel     = 1'b1;
                dec_d.mem_re    = 1'b1;
                dec_d.mem_width = funct3;
                bad_fn          = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec_d.imm       = imm_s;
                dec_d.b_sel     = 1'b1;
                dec_d.mem_we    = 1'b1;
                dec_d.mem_width = funct3;
                bad_fn          = (funct3[2] == 1'b1) || (funct3 == 3'b011);
            end
            OPC_OPIMM: begin
                dec_d.imm     = imm_i;
                dec_d.rf_we   = 1'b1;
                dec_d.din_sel = DIN_ALU;
                dec_d.b_sel   = 1'b1;
                dec_d.alu_op  = alu_from_f3(funct3, instr_i[30] & (funct3 == 3'b101));
                bad_fn        = ((funct3 == 3'b001) && (funct7 != 7'b0)) ||
                                ((funct3 == 3'b101) && (funct7 != 7'b0) && (funct7 != F7_ALT));
            end
            OPC_OP: begin
                dec_d.rf_we   = 1'b1;
                dec_d.din_sel = DIN_ALU;
                dec_d.alu_op  = alu_from_f3(funct3, instr_i[30]);
                bad_fn        = (funct7 != 7'b0) &&
                                !((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_FENCE: begin
                bad_fn = (funct3 != 3'b000);
            end
            default: known = 1'b0;
        endcase

        if (dec_d.rd == '0) begin
            dec_d.rf_we = 1'b0;
        end
        // Anything that cannot be executed leaves the bundle with no side effects.
        if (!known || bad_fn || illegal) begin
            dec_d.rf_we  = 1'b0;
            dec_d.mem_re = 1'b0;
            dec_d.mem_we = 1'b0;
            dec_d.jump   = 1'b0;
            dec_d.branch = 1'b0;
        end
        dec_d.illegal = illegal;
    end

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic rd_used, rs1_used, rs2_used;
    logic reg_bad;

    always_comb begin
        rd_used  = 1'b0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: rd_used = 1'b1;
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                rd_used  = 1'b1;
                rs1_used = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OPC_OP: begin
                rd_used  = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            default: ;
        endcase
    end

    // A register field wider than the implemented file (RV32E) is reserved.
    assign reg_bad = (rd_used  && ((instr_i[11:7]  >> RF_ADDR_W) != 5'd0)) ||
                     (rs1_used && ((instr_i[19:15] >> RF_ADDR_W) != 5'd0)) ||
                     (rs2_used && ((instr_i[24:20] >> RF_ADDR_W) != 5'd0));
    assign illegal = !known || bad_fn || reg_bad;

    logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

    always_comb begin
        ill_cnt_d = ill_cnt_q;
        if (deliver && out_q.illegal && !(&ill_cnt_q)) begin
            ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ill_cnt_q <= '0;
        end else begin
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign ill_count_o = ill_cnt_q;
`else
    assign illegal     = 1'b0;
    assign ill_count_o = '0;
`endif

    // Flush wins over every other event; an instruction accepted alongside it is dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else if (flush_i) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_q   <= dec_d;
                        valid_q <= 1'b1;
                        state_q <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !deliver) begin
                        skid_q  <= dec_d;
                        ready_q <= 1'b0;
                        state_q <= ST_TWO;
                    end else if (accept) begin
                        out_q <= dec_d;
                    end else if (deliver) begin
                        valid_q <= 1'b0;
                        state_q <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (deliver) begin
                        out_q   <= skid_q;
                        ready_q <= 1'b1;
                        state_q <= ST_ONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

    assign ready_o      = ready_q;
    assign valid_o      = valid_q;
    assign pc_o         = out_q.pc;
    assign rd_sel_o     = out_q.rd;
    assign rs1_sel_o    = out_q.rs1;
    assign rs2_sel_o    = out_q.rs2;
    assign imm_o        = out_q.imm;
    assign rf_we_o      = out_q.rf_we;
    assign rf_din_sel_o = out_q.din_sel;
    assign a_op_sel_o   = out_q.a_sel;
    assign b_op_sel_o   = out_q.b_sel;
    assign alu_op_sel_o = out_q.alu_op;
    assign jump_en_o    = out_q.jump;
    assign branch_en_o  = out_q.branch;
    assign cmp_type_o   = out_q.cmp;
    assign mem_re_o     = out_q.mem_re;
    assign mem_we_o     = out_q.mem_we;
    assign mem_width_o  = out_q.mem_width;
    assign illegal_o    = out_q.illegal;

endmodule
